recepcion_serial: RTL and testbench

//  Serial receiver for the 3-bit sda link driven by the transmision block.

---
 rtl/recepcion_serial.sv | 135 +++++++++++++
 tb/tb_recepcion_serial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/recepcion_serial.sv
// rtl/recepcion_serial.sv - serial receiver for the sda link: deserialise, glitch/range check, report
// One frame per parareloj rising edge; results appear as one-cycle valid/err pulses.
module recepcion_serial #(
   parameter int DATA_W     = 3,
   parameter int BIT_CYCLES = 2,
   parameter int MIN_CODE   = 1,
   parameter int MAX_CODE   = 6,
   parameter int ERRCNT_W   = 8
) (
   input  logic                clk2,
   input  logic                reset2,
   input  logic                sda,
   input  logic                parareloj,
   output logic [DATA_W-1:0]   dataout,
   output logic                valid,
   output logic                err,
   output logic                busy,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

   state_t                state_q, state_d;
   logic                  parareloj_q, parareloj_d;
   logic [DATA_W-1:0]     shreg_q, shreg_d;
   logic                  ref_bit_q, ref_bit_d;
   logic                  glitch_q, glitch_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [CYC_W-1:0]      cyc_q, cyc_d;
   logic [DATA_W-1:0]     dataout_q, dataout_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
   logic                  start;
   logic                  code_ok;

   assign start   = parareloj & ~parareloj_q;
   assign code_ok = (shreg_q >= DATA_W'(MIN_CODE)) && (shreg_q <= DATA_W'(MAX_CODE));

   always_comb begin
      state_d     = state_q;
      parareloj_d = parareloj;
      shreg_d     = shreg_q;
      ref_bit_d   = ref_bit_q;
      glitch_d    = glitch_q;
      bit_idx_d   = bit_idx_q;
      cyc_d       = cyc_q;
      dataout_d   = dataout_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      busy_d      = busy_q;
      err_count_d = err_count_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RECV;
               bit_idx_d = IDX_W'(DATA_W - 1);
               cyc_d     = '0;
               glitch_d  = 1'b0;
               busy_d    = 1'b1;
            end
         end
         RECV: begin
            // First clock of a bit captures it; the rest must agree or the frame is glitched.
            if (cyc_q == '0) begin
               shreg_d   = {shreg_q[DATA_W-2:0], sda};
               ref_bit_d = sda;
            end else if (sda != ref_bit_q) begin
               glitch_d = 1'b1;
            end
            if (cyc_q == CYC_W'(BIT_CYCLES - 1)) begin
               cyc_d = '0;
               if (bit_idx_q == '0) state_d = CHECK;
               else                 bit_idx_d = bit_idx_q - IDX_W'(1);
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         CHECK: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (!glitch_q && code_ok) begin
               dataout_d = shreg_q;
               valid_d   = 1'b1;
            end else begin
               err_d = 1'b1;
               if (err_count_q != '1) err_count_d = err_count_q + ERRCNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk2) begin
      if (reset2) begin
         state_q     <= IDLE;
         parareloj_q <= 1'b0;
         shreg_q     <= '0;
         ref_bit_q   <= 1'b0;
         glitch_q    <= 1'b0;
         bit_idx_q   <= '0;
         cyc_q       <= '0;
         dataout_q   <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         parareloj_q <= parareloj_d;
         shreg_q     <= shreg_d;
         ref_bit_q   <= ref_bit_d;
         glitch_q    <= glitch_d;
         bit_idx_q   <= bit_idx_d;
         cyc_q       <= cyc_d;
         dataout_q   <= dataout_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         err_count_q <= err_count_d;
      end
   end

   assign dataout   = dataout_q;
   assign valid     = valid_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_recepcion_serial.sv
// tb/tb_recepcion_serial.sv - randomized scoreboard bench for recepcion_serial
// Frames are generated as raw sda samples; a frame-level model predicts each pulse.
module tb_recepcion_serial;

   localparam int DATA_W = 3;
   localparam int BC     = 2;
   localparam int NS     = DATA_W * BC;

   logic       clk2 = 1'b0;
   logic       reset2 = 1'b1;
   logic       sda = 1'b0;
   logic       parareloj = 1'b0;
   logic [2:0] dataout;
   logic       valid, err, busy;
   logic [7:0] err_count;

   typedef struct {
      bit         ok;
      logic [2:0] dout;
      logic [7:0] ec;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc_cnt = 0;
   logic [2:0] m_dout = '0;
   logic [7:0] m_ec = '0;

   recepcion_serial dut (
      .clk2(clk2), .reset2(reset2), .sda(sda), .parareloj(parareloj),
      .dataout(dataout), .valid(valid), .err(err), .busy(busy), .err_count(err_count)
   );

   always #5 clk2 = ~clk2;
   always @(posedge clk2) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every pulse must match the oldest predicted frame outcome.
   always @(negedge clk2) begin
      if (valid || err) begin
         check("valid_err_exclusive", int'(valid && err), 0);
         check("busy_low_at_pulse", int'(busy), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind_valid", int'(valid), int'(e.ok));
            check("pulse_cycle", cyc_cnt, e.cyc);
            check("dataout", int'(dataout), int'(e.dout));
            check("err_count", int'(err_count), int'(e.ec));
         end
      end
   end

   function automatic logic [NS-1:0] mk(input logic [2:0] code, input int gpos);
      logic [NS-1:0] s;
      for (int i = 0; i < DATA_W; i++)
         for (int c = 0; c < BC; c++) s[i*BC+c] = code[DATA_W-1-i];
      if (gpos >= 0) s[gpos] = ~s[gpos];
      return s;
   endfunction

   // Reference: a frame is good when each bit is held steadily and the code is in 1..6.
   task automatic predict(input logic [NS-1:0] s, input int t);
      exp_t e;
      bit glitch = 0;
      int code = 0;
      for (int i = 0; i < DATA_W; i++) begin
         for (int c = 1; c < BC; c++) if (s[i*BC+c] != s[i*BC]) glitch = 1;
         code = code * 2 + int'(s[i*BC]);
      end
      e.ok = !glitch && code >= 1 && code <= 6;
      if (e.ok) m_dout = 3'(code);
      else if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      e.dout = m_dout;
      e.ec   = m_ec;
      e.cyc  = t + 7;
      exp_q.push_back(e);
   endtask

   // Called just after a posedge with the DUT idle and parareloj low.
   task automatic send(input logic [NS-1:0] s, input bit second_start);
      int t;
      parareloj = 1'b1;
      @(posedge clk2); #1;
      t = cyc_cnt;
      parareloj = 1'b0;
      check("busy_after_start", int'(busy), 1);
      for (int k = 0; k < NS; k++) begin
         sda = s[k];
         if (second_start && k == 3) parareloj = 1'b1;
         @(posedge clk2); #1;
      end
      parareloj = 1'b0;
      predict(s, t);
      repeat (3) begin @(posedge clk2); #1; end
   endtask

   initial begin
      logic [2:0] code;
      int gp;
      repeat (3) @(posedge clk2);
      #1;
      reset2 = 1'b0;
      check("reset_dataout", int'(dataout), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_err", int'(err), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_err_count", int'(err_count), 0);
      @(posedge clk2); #1;

      send(6'b110011, 0);
      send(6'b000000, 0);
      send(6'b111111, 0);
      send(mk(3'd6, -1), 0);
      send(6'b001110, 0);

      // Reset in the middle of a frame.
      parareloj = 1'b1;
      @(posedge clk2); #1;
      parareloj = 1'b0;
      sda = 1'b1;
      @(posedge clk2); #1;
      @(posedge clk2); #1;
      reset2 = 1'b1;
      @(posedge clk2); #1;
      reset2 = 1'b0;
      m_dout = '0;
      m_ec = '0;
      check("midreset_dataout", int'(dataout), 0);
      check("midreset_busy", int'(busy), 0);
      check("midreset_err_count", int'(err_count), 0);
      check("midreset_valid_err", int'(valid | err), 0);
      repeat (2) begin @(posedge clk2); #1; end
      send(mk(3'd2, -1), 0);

      send(mk(3'd5, -1), 1);

      for (int n = 0; n < 40; n++) begin
         code = 3'($urandom_range(0, 7));
         gp = ($urandom_range(0, 3) == 0) ? 2 * $urandom_range(0, DATA_W - 1) + 1 : -1;
         send(mk(code, gp), 0);
      end

      for (int n = 0; n < 260; n++) send(mk((n % 2) ? 3'd7 : 3'd0, -1), 0);
      check("err_count_saturated", int'(err_count), 8'hFF);

      for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk2);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
